// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response channel, branch
// redirect from MEM, and the instruction handed to the IF/ID register.
interface inst_fetch_queue_if;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        redirect;
    logic [63:0] redirect_addr;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    // The fetch queue drives requests and fetched instructions.
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
               redirect, redirect_addr, stall
    );

    // Memory / pipeline side of the same bus.
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
               redirect, redirect_addr, stall
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupled instruction-fetch front end. Issues word requests from fetch_pc,
// remembers in-flight addresses, buffers returned instructions in a FIFO and
// squashes wrong-path responses after a MEM-stage redirect. Outstanding
// requests plus buffered entries never exceed DEPTH, so the FIFO cannot
// overflow and the memory never needs back-pressure on responses.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                CLK,
    input logic                RST,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [63:0]   fetch_pc_r;
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [63:0]   fifo_addr_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [63:0]   aq_addr_r [DEPTH];
    logic [PW-1:0] aq_head_r;
    logic [PW-1:0] aq_tail_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;

    logic [CW:0]   credit_used_s;
    logic          req_fire_s;
    logic          resp_ok_s;
    logic          resp_keep_s;
    logic          pop_s;
    logic [63:0]   target_s;

    // Credits: every in-flight request reserves a FIFO slot.
    assign credit_used_s = {1'b0, outstanding_r} + {1'b0, count_r};
    assign bus.imem_req_valid = !RST && !bus.redirect && (credit_used_s < DEPTH_C);
    assign bus.imem_req_addr  = fetch_pc_r;

    assign req_fire_s  = bus.imem_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding (e.g. stale across reset) is ignored.
    assign resp_ok_s   = bus.imem_resp_valid && (outstanding_r != CW'(0));
    assign resp_keep_s = resp_ok_s && (drop_cnt_r == CW'(0)) && !bus.redirect;
    assign pop_s       = (count_r != CW'(0)) && !bus.stall && !bus.redirect;
    assign target_s    = bus.redirect_addr & ~64'h3;

    // Present the FIFO head, or a NOP bubble when empty.
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst       = NOP;
        bus.inst_addr  = 64'h0;
        if (count_r != CW'(0)) begin
            bus.inst_valid = 1'b1;
            bus.inst       = fifo_inst_r[head_r];
            bus.inst_addr  = fifo_addr_r[head_r];
        end else begin
            bus.inst_valid = 1'b0;
        end
    end

    // Fetch PC: redirect target wins, otherwise advance on each accepted request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc_r <= target_s;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + 64'd4;
        end
    end

    // In-flight address queue pointers and outstanding request count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aq_head_r     <= PW'(0);
            aq_tail_r     <= PW'(0);
            outstanding_r <= CW'(0);
        end else begin
            if (req_fire_s) begin
                aq_tail_r <= aq_tail_r + PW'(1);
            end
            if (resp_ok_s) begin
                aq_head_r <= aq_head_r + PW'(1);
            end
            if (req_fire_s && !resp_ok_s) begin
                outstanding_r <= outstanding_r + CW'(1);
            end else if (!req_fire_s && resp_ok_s) begin
                outstanding_r <= outstanding_r - CW'(1);
            end
        end
    end

    // Wrong-path drain counter: everything still in flight at a redirect is
    // discarded, including a response landing in the redirect cycle itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt_r <= CW'(0);
        end else if (bus.redirect) begin
            drop_cnt_r <= resp_ok_s ? (outstanding_r - CW'(1)) : outstanding_r;
        end else if (resp_ok_s && (drop_cnt_r != CW'(0))) begin
            drop_cnt_r <= drop_cnt_r - CW'(1);
        end
    end

    // FIFO pointers and occupancy; a redirect flushes without counting a pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_r  <= PW'(0);
            tail_r  <= PW'(0);
            count_r <= CW'(0);
        end else if (bus.redirect) begin
            head_r  <= PW'(0);
            tail_r  <= PW'(0);
            count_r <= CW'(0);
        end else begin
            if (resp_keep_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            if (resp_keep_s && !pop_s) begin
                count_r <= count_r + CW'(1);
            end else if (!resp_keep_s && pop_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Payload storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge CLK) begin
        if (req_fire_s) begin
            aq_addr_r[aq_tail_r] <= fetch_pc_r;
        end
        if (resp_keep_s) begin
            fifo_inst_r[tail_r] <= bus.imem_resp_inst;
            fifo_addr_r[tail_r] <= aq_addr_r[aq_head_r];
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a latency-programmable memory model,
// a scoreboard of expected delivered addresses, and a monitor that checks
// every instruction IF/ID actually takes.
module tb_inst_fetch_queue;
    logic CLK;
    logic RST;
    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int gen    = 0;
    int lat    = 1;
    int cyc    = 0;
    int req_cnt = 0;
    bit hold   = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] inst_of(input logic [63:0] a, input int g);
        return {g[7:0], a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // In-order memory: responds lat cycles after acceptance, one per cycle.
    always begin
        logic        acc;
        logic [63:0] acc_addr;
        pend_t       p;
        @(negedge CLK);
        acc      = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
        @(posedge CLK);
        if (bus.imem_resp_valid && pend.size() > 0) p = pend.pop_front();
        cyc++;
        if (acc) begin
            p.addr = acc_addr;
            p.inst = inst_of(acc_addr, gen);
            p.due  = cyc + lat - 1;
            pend.push_back(p);
            req_cnt++;
        end
        #2;
        if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_inst  = pend[0].inst;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_inst  = 32'h0;
        end
    end

    // Monitor: checks each consumed instruction against the scoreboard.
    always @(negedge CLK) begin
        logic [63:0] e;
        if (bus.inst_valid) begin
            if (!bus.stall && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got addr %h, required none", bus.inst_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_addr", bus.inst_addr, e);
                    chk("inst", {32'h0, bus.inst}, {32'h0, inst_of(e, gen)});
                end
            end
        end else begin
            chk("idle_inst", {32'h0, bus.inst}, 64'h13);
            chk("idle_addr", bus.inst_addr, 64'h0);
        end
    end

    task automatic do_reset();
        tick();
        RST = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = 64'h0;
        bus.stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        hold = 1'b0;
        pend.delete();
        exp_q.delete();
        gen++;
        req_cnt = 0;
        tick();
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        chk(name, exp_q.size(), 64'd0);
        bus.stall = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_addr = 64'h0;
        bus.stall = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst = 32'h0;

        // Reset values
        do_reset();
        at_neg();
        chk("rst_req_valid", bus.imem_req_valid, 64'd0);
        chk("rst_inst_valid", bus.inst_valid, 64'd0);
        chk("rst_inst", {32'h0, bus.inst}, 64'h13);
        chk("rst_inst_addr", bus.inst_addr, 64'h0);

        // Free run, latency 1
        do_reset();
        lat = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));
        RST = 1'b0;
        at_neg();
        chk("fr_c1_req_valid", bus.imem_req_valid, 64'd1);
        chk("fr_c1_req_addr", bus.imem_req_addr, 64'h0);
        chk("fr_c1_inst_valid", bus.inst_valid, 64'd0);
        tick(); at_neg();
        chk("fr_c2_req_addr", bus.imem_req_addr, 64'h4);
        chk("fr_c2_inst_valid", bus.inst_valid, 64'd0);
        tick(); at_neg();
        chk("fr_c3_inst_valid", bus.inst_valid, 64'd1);
        drain("fr_drain");

        // Stall fills the queue, then drains in order
        do_reset();
        lat = 2;
        for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));
        RST = 1'b0;
        tick();
        bus.stall = 1'b1;
        repeat (8) tick();
        at_neg();
        chk("st_req_valid_full", bus.imem_req_valid, 64'd0);
        chk("st_req_cnt", 64'(req_cnt), 64'd4);
        chk("st_head_addr", bus.inst_addr, 64'h0);
        tick();
        bus.stall = 1'b0;
        at_neg();
        chk("st_req_valid_pop", bus.imem_req_valid, 64'd0);
        tick(); at_neg();
        chk("st_resume_valid", bus.imem_req_valid, 64'd1);
        chk("st_resume_addr", bus.imem_req_addr, 64'h10);
        drain("st_drain");

        // Redirect with 3 in flight and a response in the same cycle
        do_reset();
        lat = 1;
        hold = 1'b1;
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h104);
        exp_q.push_back(64'h108);
        RST = 1'b0;
        tick(); tick(); tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'h103;
        hold = 1'b0;
        at_neg();
        chk("rd_in_flight", 64'(req_cnt), 64'd3);
        chk("rd_req_blocked", bus.imem_req_valid, 64'd0);
        tick();
        bus.redirect = 1'b0;
        at_neg();
        chk("rd_req_target", bus.imem_req_addr, 64'h100);
        chk("rd_req_valid", bus.imem_req_valid, 64'd1);
        chk("rd_bubble_r1", bus.inst_valid, 64'd0);
        tick(); at_neg();
        chk("rd_bubble_r2", bus.inst_valid, 64'd0);
        tick(); at_neg();
        chk("rd_bubble_r3", bus.inst_valid, 64'd0);
        drain("rd_drain");

        // Back-to-back redirects, latency 3
        do_reset();
        lat = 3;
        bus.stall = 1'b1;
        exp_q.push_back(64'h300);
        exp_q.push_back(64'h304);
        exp_q.push_back(64'h308);
        RST = 1'b0;
        repeat (4) tick();
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'h200;
        bus.stall = 1'b0;
        at_neg();
        chk("bb_req_blocked1", bus.imem_req_valid, 64'd0);
        tick();
        bus.redirect_addr = 64'h300;
        at_neg();
        chk("bb_bubble1", bus.inst_valid, 64'd0);
        chk("bb_req_blocked2", bus.imem_req_valid, 64'd0);
        tick();
        bus.redirect = 1'b0;
        at_neg();
        chk("bb_bubble2", bus.inst_valid, 64'd0);
        chk("bb_req_addr", bus.imem_req_addr, 64'h300);
        drain("bb_drain");

        // PC wrap at the top of the address space
        do_reset();
        lat = 1;
        bus.redirect = 1'b1;
        bus.redirect_addr = 64'hFFFF_FFFF_FFFF_FFFE;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        RST = 1'b0;
        at_neg();
        chk("wr_req_blocked", bus.imem_req_valid, 64'd0);
        tick();
        bus.redirect = 1'b0;
        at_neg();
        chk("wr_req_top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); at_neg();
        chk("wr_req_wrap", bus.imem_req_addr, 64'h0);
        drain("wr_drain");

        // Reset mid-flight, stale responses afterwards
        do_reset();
        lat = 1;
        hold = 1'b1;
        RST = 1'b0;
        tick(); tick();
        RST = 1'b1;
        bus.imem_req_ready = 1'b0;
        gen++;
        at_neg();
        chk("mr_req_valid", bus.imem_req_valid, 64'd0);
        chk("mr_inst_valid", bus.inst_valid, 64'd0);
        chk("mr_inst", {32'h0, bus.inst}, 64'h13);
        tick();
        RST = 1'b0;
        hold = 1'b0;
        at_neg();
        chk("mr_restart_valid", bus.imem_req_valid, 64'd1);
        chk("mr_restart_addr", bus.imem_req_addr, 64'h0);
        tick(); at_neg();
        chk("mr_stale_ignored1", bus.inst_valid, 64'd0);
        tick();
        bus.imem_req_ready = 1'b1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h4);
        exp_q.push_back(64'h8);
        at_neg();
        chk("mr_stale_ignored2", bus.inst_valid, 64'd0);
        drain("mr_drain");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

- Decoupled instruction-fetch front end for the pipelined RV64 core; replaces the combinational PC → instruction-memory path in front of the IF/ID register.
- Keeps the fetch PC and issues word requests to an instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their addresses in a small FIFO and presents them to IF/ID.
- Squashes wrong-path fetches when the MEM-stage branch decision redirects the PC.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; also the cap on outstanding requests plus buffered entries (power of two, ≥2).
- RESET_PC, 64'h0: fetch address after reset.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_addr  out  64  word address of request; bits [1:0] always 0.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_inst  in  32  returned instruction.
- redirect  in  1  taken branch from the MEM stage (PCSrc).
- redirect_addr  in  64  branch target (branch_addr_MEM); bits [1:0] are ignored and treated as 0.
- stall  in  1  downstream is not accepting this cycle.
- inst_valid  out  1  inst/inst_addr hold a valid fetched instruction.
- inst  out  32  instruction to IF/ID; 32'h00000013 (NOP) when inst_valid=0.
- inst_addr  out  64  address of inst; 0 when inst_valid=0.

## Operation
State:
- fetch_pc: 64-bit.
- FIFO: DEPTH × {inst, addr}, with count.
- addr_q: DEPTH-entry queue of in-flight request addresses.
- outstanding: 0..DEPTH.
- drop_cnt: 0..DEPTH.

Reset (async):
- fetch_pc=RESET_PC; FIFO, addr_q, outstanding and drop_cnt cleared.
- imem_req_valid=0, inst_valid=0, inst=NOP, inst_addr=0.

Request issue:
- imem_req_valid = !RST && !redirect && (outstanding + count < DEPTH).
- imem_req_addr = fetch_pc.
- On valid&&ready: push fetch_pc to addr_q, outstanding+1, fetch_pc += 4 (wraps modulo 2^64).

Response:
- On imem_resp_valid: pop addr_q and decrement outstanding.
- If drop_cnt>0, discard the response and decrement drop_cnt.
- Otherwise write {imem_resp_inst, popped addr} to the FIFO tail.
- imem_resp_valid with outstanding=0 is a protocol violation; ignore it and leave state unchanged.

Consume:
- inst_valid = count>0; inst and inst_addr show the FIFO head.
- Head pops when inst_valid && !stall && !redirect.

Redirect (has priority over everything else in its cycle):
- FIFO flushed (count=0); no pop is counted.
- fetch_pc = {redirect_addr[63:2], 2'b00}.
- drop_cnt = outstanding − (imem_resp_valid ? 1 : 0); a response arriving this cycle is itself discarded.
- No request is issued this cycle.
- A second redirect during draining recomputes drop_cnt by the same rule.

Invariants:
- outstanding + count ≤ DEPTH at all times, so the FIFO never overflows.
- Simultaneous push and pop on a full or empty FIFO: both take effect and count is unchanged.

## Timing
- Request accepted at edge t → earliest response in cycle t+1 → entry visible on inst_valid in cycle t+2.
- No FIFO bypass.
- Redirect asserted in cycle r:
  - inst_valid=0 in r+1.
  - First request to the target is issued in r+1.
  - Its instruction appears no earlier than r+3.
- Sustained throughput is 1 instruction/cycle when memory latency ≤ DEPTH−1 and stall=0.
- stall held: FIFO fills and requests stop at outstanding + count = DEPTH; they resume the cycle after a pop frees a credit.
- RST asserted mid-operation: state clears immediately (async); responses to pre-reset requests that arrive after reset are ignored per the outstanding=0 rule.

## Test plan
- Reset then free-run, memory latency 1, ready=1 → requests to 0x0, 0x4, 0x8…; inst_valid first high in cycle 3 after reset release; one instruction/cycle with matching inst_addr.
- stall=1 from cycle 2, latency 2, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; release stall → the 4 entries drain in order 0x0–0xC, then the next request is 0x10.
- 3 requests in flight, redirect to 0x103 with one response arriving in the same cycle → drop_cnt=2; the next 2 responses are discarded; first request goes to 0x100; inst_addr 0x100 is delivered.
- Back-to-back redirects (0x200, then 0x300 the next cycle) with latency 3 → no instruction from 0x200 or the old path reaches inst_valid; first delivered inst_addr = 0x300.
- fetch_pc = 0xFFFFFFFFFFFFFFFC → next request address is 0x0 (wrap).
- RST pulsed while 2 requests are outstanding, then a stale response arrives → outputs return to reset values and the stale response is ignored; fetch restarts at RESET_PC.
